seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised Moore-style serial sequence detector with a runtime-programmable pattern of 1..MAX_LEN bits. Overlapping or non-overlapping matching is selectable, and a saturating match counter is included. It is the next generation of the fixed 5-bit "11010" detector and sits on the serial input path of the test designs. Reset defaults reproduce the fixed detector exactly: pattern 11010 with overlap enabled.

## Interface
Parameters:
- MAX_LEN, default 8: maximum pattern length in bits; must be at least 5.
- LEN_W, default 4: width of the pattern-length field; must satisfy 2^LEN_W > MAX_LEN.
- CNT_W, default 8: width of the match counter.

Ports:
- clk, input, 1: single clock; all state changes on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- inp, input, 1: serial data bit.
- in_valid, input, 1: inp is sampled only on edges where in_valid=1.
- overlap, input, 1: 1 = overlapping matches allowed; 0 = non-overlapping. Sampled every edge.
- pat_load, input, 1: load pat_val and pat_len into the configuration registers.
- pat_val, input, MAX_LEN: pattern bits. The first-received bit compares with pat_val[len-1], the last-received bit with pat_val[0].
- pat_len, input, LEN_W: pattern length.
- outp, output, 1: registered match flag.
- match_cnt, output, CNT_W: saturating count of matches.
- state, output, LEN_W: match-progress register (fill), i.e. the number of valid bits held since the last clear, saturating at len.

## Operation
Internal registers:
- cfg_pat (MAX_LEN bits) and cfg_len (LEN_W bits).
- hist (MAX_LEN-bit shift register; the newest bit is at bit 0).
- fill (the state output).
- outp and match_cnt.

Reset (rst=1 at an edge) sets:
- cfg_pat = 5'b11010, zero-extended; cfg_len = 5.
- hist = 0, fill = 0, outp = 0, match_cnt = 0.
- Reset overrides every other input.

Configuration load (pat_load=1, rst=0):
- cfg_pat <= pat_val and cfg_len <= clamp(pat_len).
- clamp rule: 0 -> 1; values above MAX_LEN -> MAX_LEN; otherwise unchanged.
- hist, fill, outp and match_cnt are all cleared.
- pat_load has priority over in_valid; a bit presented in the same cycle is dropped.

Sample edge (in_valid=1, rst=0, pat_load=0):
- hist <= {hist[MAX_LEN-2:0], inp}.
- fill_next = min(fill+1, cfg_len).
- match = (fill_next == cfg_len) and (the low cfg_len bits of the new hist equal the low cfg_len bits of cfg_pat). Bits above cfg_len are ignored.
- outp <= match.
- If match: match_cnt increments, saturating at 2^CNT_W-1 with no wrap.
- If match and overlap=0: fill <= 0, so the next match needs cfg_len fresh bits. Otherwise fill <= fill_next.

Idle edge (in_valid=0, rst=0, pat_load=0):
- hist, fill and match_cnt hold.
- outp <= 0.

Behaviour notes:
- Detection is a pure window comparison, so no partial-match fallback logic is needed. Overlapping detection is exact for any pattern.
- Changing overlap mid-stream takes effect on the next sample edge.

## Timing
- outp is Moore-style and registered. It rises on the edge that samples the completing bit and is visible for exactly one cycle, unless the next edge samples another completing bit.
- Latency from a bit presented to a visible match is 1 cycle.
- outp has no combinational path from any input.
- match_cnt updates on the same edge as outp.
- Reset value of every output is 0, including state.
- Reset asserted mid-sequence discards all partial progress. Loaded configuration reverts to the defaults (11010, length 5).
- The first possible match after reset or load comes on the cfg_len-th sample edge.
- Throughput: one bit per cycle, with no stall or back-pressure.

## Test plan
1. Default pattern: reset, then feed 1,1,0,1,0 with in_valid=1. Expect outp=1 only in the cycle after the 5th bit, match_cnt=1, and state progressing 1,2,3,4,5.
2. Overlap mode: load pat_val=3'b101, pat_len=3. Feed 1,0,1,0,1.
   - With overlap=1: outp pulses after bits 3 and 5; match_cnt=2.
   - With overlap=0: a single pulse after bit 3; match_cnt=1; state=2 after bit 5.
3. Valid gaps: feed 11010 with in_valid=0 bubbles of 0-3 cycles between bits. Expect one pulse after the last valid bit, and outp=0 during every bubble.
4. Load and reset mid-stream:
   - pat_load asserted after 3 bits of 11010, together with in_valid=1: the bit is dropped and all state is cleared.
   - rst after 4 bits: no match from the remaining bit; the configuration returns to 11010.
5. Clamp and saturation with CNT_W=2:
   - pat_len=0 with pat_val[0]=1: every 1 matches; match_cnt sticks at 3 after the 3rd match.
   - pat_len=15 with MAX_LEN=8: the length is clamped to 8.
6. Back-to-back full-length pattern: MAX_LEN=8, pattern 8'hFF, overlap=1, feed ten 1s. Expect outp high for 3 consecutive cycles and match_cnt=3.

Source files
------------

// File: rtl/seq_detector_param.sv
// ---------------------------------------------------------------------------
// seq_detector_param
//
// Serial sequence detector with a runtime-programmable pattern of 1..MAX_LEN
// bits. Detection compares a window of the most recent received bits against
// the configured pattern. The window is only trusted once enough fresh bits
// have arrived. Overlapping and non-overlapping matching are both supported,
// and a saturating match counter is included. Reset defaults reproduce the
// legacy fixed "11010" detector with overlap enabled.
//
// Parameters:
//   MAX_LEN  maximum pattern length (>= 5)
//   LEN_W    width of the length field (2**LEN_W > MAX_LEN)
//   CNT_W    width of the match counter
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (overrides everything)
//   inp        serial data bit, sampled when in_valid=1
//   in_valid   qualifies inp
//   overlap    1 = overlapping matches, 0 = non-overlapping
//   pat_load   load pat_val/pat_len and clear all progress
//   pat_val    pattern; first-received bit aligns with pat_val[len-1]
//   pat_len    pattern length (clamped to 1..MAX_LEN on load)
//   outp       registered one-cycle match pulse
//   match_cnt  saturating number of matches
//   state      fill level: valid bits held since last clear, max cfg_len
// ---------------------------------------------------------------------------
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inp,
    input  logic               in_valid,
    input  logic               overlap,
    input  logic               pat_load,
    input  logic [MAX_LEN-1:0] pat_val,
    input  logic [LEN_W-1:0]   pat_len,
    output logic               outp,
    output logic [CNT_W-1:0]   match_cnt,
    output logic [LEN_W-1:0]   state
);

    localparam logic [MAX_LEN-1:0] DEF_PAT   = MAX_LEN'(5'b11010);
    localparam logic [LEN_W-1:0]   DEF_LEN   = LEN_W'(5);
    localparam logic [LEN_W-1:0]   MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

    // Map a requested length onto the supported range 1..MAX_LEN.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        logic [LEN_W-1:0] r;
        if (len == {LEN_W{1'b0}}) begin
            r = LEN_W'(1);
        end else if (len > MAX_LEN_L) begin
            r = MAX_LEN_L;
        end else begin
            r = len;
        end
        return r;
    endfunction

    // Mask that selects the low 'len' bits of the window.
    function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
        logic [MAX_LEN-1:0] m;
        for (int i = 0; i < MAX_LEN; i++) begin
            m[i] = (i < int'(len));
        end
        return m;
    endfunction

    logic [MAX_LEN-1:0] cfg_pat_q,   cfg_pat_d;
    logic [LEN_W-1:0]   cfg_len_q,   cfg_len_d;
    logic [MAX_LEN-1:0] hist_q,      hist_d;
    logic [LEN_W-1:0]   fill_q,      fill_d;
    logic               outp_q,      outp_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;

    logic [MAX_LEN-1:0] hist_shift_s;
    logic [LEN_W:0]     fill_inc_s;
    logic [LEN_W-1:0]   fill_next_s;
    logic               match_s;

    // Window compare on the would-be history, plus next-state selection.
    always_comb begin
        cfg_pat_d   = cfg_pat_q;
        cfg_len_d   = cfg_len_q;
        hist_d      = hist_q;
        fill_d      = fill_q;
        outp_d      = 1'b0;
        match_cnt_d = match_cnt_q;

        hist_shift_s = {hist_q[MAX_LEN-2:0], inp};
        // One extra bit so fill+1 cannot wrap when MAX_LEN == 2**LEN_W-1.
        fill_inc_s   = {1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1};
        if (fill_inc_s > {1'b0, cfg_len_q}) begin
            fill_next_s = cfg_len_q;
        end else begin
            fill_next_s = fill_inc_s[LEN_W-1:0];
        end
        // The fill gate keeps stale or reset-zero history from matching.
        match_s = (fill_next_s == cfg_len_q) &&
                  (((hist_shift_s ^ cfg_pat_q) & len_mask(cfg_len_q)) == {MAX_LEN{1'b0}});

        if (pat_load) begin
            cfg_pat_d   = pat_val;
            cfg_len_d   = clamp_len(pat_len);
            hist_d      = {MAX_LEN{1'b0}};
            fill_d      = {LEN_W{1'b0}};
            match_cnt_d = {CNT_W{1'b0}};
        end else if (in_valid) begin
            hist_d = hist_shift_s;
            outp_d = match_s;
            if (match_s && (match_cnt_q != CNT_MAX)) begin
                match_cnt_d = match_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                match_cnt_d = match_cnt_q;
            end
            // Non-overlapping mode needs a full set of fresh bits after a hit.
            if (match_s && !overlap) begin
                fill_d = {LEN_W{1'b0}};
            end else begin
                fill_d = fill_next_s;
            end
        end else begin
            outp_d = 1'b0;
        end
    end

    // State registers with synchronous reset to the legacy configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_pat_q   <= DEF_PAT;
            cfg_len_q   <= DEF_LEN;
            hist_q      <= {MAX_LEN{1'b0}};
            fill_q      <= {LEN_W{1'b0}};
            outp_q      <= 1'b0;
            match_cnt_q <= {CNT_W{1'b0}};
        end else begin
            cfg_pat_q   <= cfg_pat_d;
            cfg_len_q   <= cfg_len_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            outp_q      <= outp_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    assign outp      = outp_q;
    assign match_cnt = match_cnt_q;
    assign state     = fill_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// ---------------------------------------------------------------------------
// tb_seq_detector_param
//
// Two detector instances share all inputs: one with an 8-bit counter and one
// with a 2-bit counter, which makes saturation visible. A bit-queue reference
// model tracks the expected outputs. A directed vector table, hand-written
// corner sequences and a randomized run are all checked against the model
// and against explicit constants.
// ---------------------------------------------------------------------------
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst, inp, in_valid, overlap, pat_load;
    logic [7:0] pat_val;
    logic [3:0] pat_len;
    logic       outp8, outp2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;
    logic [3:0] state8, state2;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] m_pat;
    int         m_len;
    bit         m_bits[$];
    int         m_fresh;
    int         m_cnt;
    bit         m_outp;

    seq_detector_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .overlap(overlap),
        .pat_load(pat_load), .pat_val(pat_val), .pat_len(pat_len),
        .outp(outp8), .match_cnt(cnt8), .state(state8)
    );

    seq_detector_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .overlap(overlap),
        .pat_load(pat_load), .pat_val(pat_val), .pat_len(pat_len),
        .outp(outp2), .match_cnt(cnt2), .state(state2)
    );

    // Free-running clock
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       iv;
        logic       b;
        logic       ovl;
        logic       ld;
        logic [7:0] pv;
        logic [3:0] pl;
        logic       eo;
        logic [7:0] ec;
        logic [3:0] es;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Behavioural reference: remembers received bits, counts fresh bits.
    task automatic model_edge();
        bit hit;
        if (rst) begin
            m_pat = 8'b0001_1010; m_len = 5;
            m_bits.delete(); m_fresh = 0; m_outp = 1'b0; m_cnt = 0;
        end else if (pat_load) begin
            m_pat = pat_val;
            if (pat_len == 4'd0)      m_len = 1;
            else if (pat_len > 4'd8)  m_len = 8;
            else                      m_len = int'(pat_len);
            m_bits.delete(); m_fresh = 0; m_outp = 1'b0; m_cnt = 0;
        end else if (in_valid) begin
            m_bits.push_front(inp);
            if (m_bits.size() > 8) void'(m_bits.pop_back());
            m_fresh++;
            hit = (m_fresh >= m_len) && (m_bits.size() >= m_len);
            for (int k = 0; k < 8; k++) begin
                if (hit && k < m_len && m_bits[k] != m_pat[k]) hit = 1'b0;
            end
            m_outp = hit;
            if (hit) m_cnt++;
            if (hit && !overlap) m_fresh = 0;
        end else begin
            m_outp = 1'b0;
        end
    endtask

    // One clock: update model with the applied inputs, compare after the edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("outp8",  int'(outp8),  int'(m_outp));
        chk("outp2",  int'(outp2),  int'(m_outp));
        chk("cnt8",   int'(cnt8),   imin(m_cnt, 255));
        chk("cnt2",   int'(cnt2),   imin(m_cnt, 3));
        chk("state8", int'(state8), imin(m_fresh, m_len));
        chk("state2", int'(state2), imin(m_fresh, m_len));
    endtask

    task automatic drive(input logic r, input logic iv, input logic b, input logic ovl,
                         input logic ld, input logic [7:0] pv, input logic [3:0] pl);
        rst = r; in_valid = iv; inp = b; overlap = ovl;
        pat_load = ld; pat_val = pv; pat_len = pl;
        step();
    endtask

    task automatic bit_in(input logic b, input logic ovl);
        drive(1'b0, 1'b1, b, ovl, 1'b0, 8'h00, 4'd0);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0);
    endtask

    task automatic do_load(input logic [7:0] pv, input logic [3:0] pl, input logic ovl);
        drive(1'b0, 1'b0, 1'b0, ovl, 1'b1, pv, pl);
    endtask

    initial begin
        vec_t tbl[$];
        logic [7:0] lp;
        int highs;

        rst = 1'b1; inp = 1'b0; in_valid = 1'b0; overlap = 1'b1;
        pat_load = 1'b0; pat_val = 8'h00; pat_len = 4'd0;
        m_pat = 8'h00; m_len = 5; m_fresh = 0; m_cnt = 0; m_outp = 1'b0;

        // Default 11010 detection, then a 101 pattern with and without overlap
        tbl.push_back('{1'b1,1'b0,1'b0,1'b1,1'b0,8'h00,4'd0, 1'b0,8'd0,4'd0});
        tbl.push_back('{1'b0,1'b1,1'b1,1'b1,1'b0,8'h00,4'd0, 1'b0,8'd0,4'd1});
        tbl.push_back('{1'b0,1'b1,1'b1,1'b1,1'b0,8'h00,4'd0, 1'b0,8'd0,4'd2});
        tbl.push_back('{1'b0,1'b1,1'b0,1'b1,1'b0,8'h00,4'd0, 1'b0,8'd0,4'd3});
        tbl.push_back('{1'b0,1'b1,1'b1,1'b1,1'b0,8'h00,4'd0, 1'b0,8'd0,4'd4});
        tbl.push_back('{1'b0,1'b1,1'b0,1'b1,1'b0,8'h00,4'd0, 1'b1,8'd1,4'd5});
        tbl.push_back('{1'b0,1'b0,1'b0,1'b1,1'b0,8'h00,4'd0, 1'b0,8'd1,4'd5});
        tbl.push_back('{1'b0,1'b0,1'b0,1'b1,1'b1,8'h05,4'd3, 1'b0,8'd0,4'd0});
        tbl.push_back('{1'b0,1'b1,1'b1,1'b1,1'b0,8'h00,4'd0, 1'b0,8'd0,4'd1});
        tbl.push_back('{1'b0,1'b1,1'b0,1'b1,1'b0,8'h00,4'd0, 1'b0,8'd0,4'd2});
        tbl.push_back('{1'b0,1'b1,1'b1,1'b1,1'b0,8'h00,4'd0, 1'b1,8'd1,4'd3});
        tbl.push_back('{1'b0,1'b1,1'b0,1'b1,1'b0,8'h00,4'd0, 1'b0,8'd1,4'd3});
        tbl.push_back('{1'b0,1'b1,1'b1,1'b1,1'b0,8'h00,4'd0, 1'b1,8'd2,4'd3});
        tbl.push_back('{1'b0,1'b0,1'b0,1'b0,1'b1,8'h05,4'd3, 1'b0,8'd0,4'd0});
        tbl.push_back('{1'b0,1'b1,1'b1,1'b0,1'b0,8'h00,4'd0, 1'b0,8'd0,4'd1});
        tbl.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0,8'h00,4'd0, 1'b0,8'd0,4'd2});
        tbl.push_back('{1'b0,1'b1,1'b1,1'b0,1'b0,8'h00,4'd0, 1'b1,8'd1,4'd0});
        tbl.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0,8'h00,4'd0, 1'b0,8'd1,4'd1});
        tbl.push_back('{1'b0,1'b1,1'b1,1'b0,1'b0,8'h00,4'd0, 1'b0,8'd1,4'd2});

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].iv, tbl[i].b, tbl[i].ovl, tbl[i].ld, tbl[i].pv, tbl[i].pl);
            chk("tbl_outp",  int'(outp8),  int'(tbl[i].eo));
            chk("tbl_cnt",   int'(cnt8),   int'(tbl[i].ec));
            chk("tbl_state", int'(state8), int'(tbl[i].es));
        end

        // Valid gaps: bubbles of 0..3 idle cycles between the bits of 11010
        do_reset();
        lp = 8'b0001_1010;
        for (int i = 4; i >= 0; i--) begin
            bit_in(lp[i], 1'b1);
            if (i != 0) begin
                for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0);
                    chk("gap_outp", int'(outp8), 0);
                end
            end
        end
        chk("gap_match", int'(outp8), 1);
        chk("gap_cnt", int'(cnt8), 1);

        // Load with in_valid high drops the bit and clears progress
        do_reset();
        bit_in(1'b1, 1'b1); bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h1A, 4'd5);
        chk("load_state", int'(state8), 0);
        chk("load_outp", int'(outp8), 0);
        bit_in(1'b1, 1'b1); bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1);
        bit_in(1'b0, 1'b1);
        chk("load_match", int'(outp8), 1);

        // Reset mid-stream discards progress and restores the default pattern
        do_load(8'h05, 4'd3, 1'b1);
        bit_in(1'b1, 1'b1); bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1);
        do_reset();
        bit_in(1'b0, 1'b1);
        chk("rst_outp", int'(outp8), 0);
        chk("rst_state", int'(state8), 1);
        do_reset();
        bit_in(1'b1, 1'b1); bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1);
        bit_in(1'b0, 1'b1);
        chk("rst_default", int'(outp8), 1);

        // Length 0 clamps to 1; 2-bit counter sticks at 3
        do_load(8'h01, 4'd0, 1'b1);
        for (int i = 0; i < 5; i++) bit_in(1'b1, 1'b1);
        chk("sat_cnt2", int'(cnt2), 3);
        chk("sat_cnt8", int'(cnt8), 5);
        chk("len1_state", int'(state8), 1);

        // Length 15 clamps to 8
        do_load(8'hA5, 4'd15, 1'b1);
        lp = 8'hA5;
        for (int i = 7; i >= 0; i--) bit_in(lp[i], 1'b1);
        chk("clamp_state", int'(state8), 8);
        chk("clamp_match", int'(outp8), 1);

        // Back-to-back full-length matches
        do_load(8'hFF, 4'd8, 1'b1);
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            bit_in(1'b1, 1'b1);
            if (outp8) highs++;
        end
        chk("ff_highs", highs, 3);
        chk("ff_cnt", int'(cnt8), 3);
        chk("ff_outp_last", int'(outp8), 1);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = int'($urandom_range(0, 199));
            drive(r < 1, $urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom),
                  (r >= 1) && (r < 6), 8'($urandom), 4'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
